// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion sequencer: one round key per clock into an
// 11-entry round-key store, read back with one cycle of latency.

module word (
    input  logic [31:0] w,
    input  logic [3:0]  rnd,
    output logic [31:0] t
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box built from the GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gmul(a, a);
        x3   = gmul(x2, a);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        inv  = gmul(gmul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]  rcon;
    logic [31:0] rot;

    always_comb begin
        rcon = 8'h00;
        case (rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign rot = {w[23:0], w[31:24]};
    assign t   = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]),
                  sbox(rot[15:8]), sbox(rot[7:0])};

endmodule

module aes_key_sched_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_key,
    output logic         busy,
    output logic         key_ready,
    output logic         done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [3:0] LAST   = 4'(NR);

    logic [1:0]   state;
    logic [3:0]   rnd;
    logic [127:0] prev;
    logic [127:0] store [0:NR];
    logic [31:0]  t;
    logic [31:0]  n0, n1, n2, n3;
    logic         accept;

    word u_word (
        .w   (prev[31:0]),
        .rnd (rnd),
        .t   (t)
    );

    assign n0     = prev[127:96] ^ t;
    assign n1     = prev[95:64] ^ n0;
    assign n2     = prev[63:32] ^ n1;
    assign n3     = prev[31:0] ^ n2;
    assign accept = start && (state != EXPAND);
    assign busy   = (state == EXPAND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rnd       <= '0;
            prev      <= '0;
            key_ready <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state     <= EXPAND;
                prev      <= key_in;
                rnd       <= 4'd1;
                key_ready <= 1'b0;
            end else if (state == EXPAND) begin
                prev <= {n0, n1, n2, n3};
                rnd  <= rnd + 4'd1;
                if (rnd == LAST) begin
                    state     <= DONE;
                    key_ready <= 1'b1;
                    done      <= 1'b1;
                end
            end
        end
    end

    // Reads see the pre-edge contents, so a same-edge write returns old data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) store[i] <= '0;
            rd_key <= '0;
        end else begin
            if (accept) store[0] <= key_in;
            else if (state == EXPAND) store[rnd] <= {n0, n1, n2, n3};
            rd_key <= (int'(rd_addr) <= NR) ? store[rd_addr] : '0;
        end
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequencer for the AES-128 key-expansion word function (RotWord/SubWord/Rcon stage, module `word`). Expands a 128-bit cipher key into the 11 round keys by iterating a single `word` instance, one round per clock. Results go into an internal 11×128 round-key store. The cipher datapath reads the store by round index once `key_ready` is high.

## Interface
Parameters:
- `NR`, 10, number of rounds; fixed at 10 for AES-128, so the store holds `NR+1` entries.

Ports:
- `clk`, input, 1, the single clock; all state is rising-edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `start`, input, 1, single-cycle request to begin expansion of `key_in`.
- `key_in`, input, 128, cipher key as `{w0,w1,w2,w3}` with w0 in bits [127:96]; sampled only when `start` is accepted.
- `rd_addr`, input, 4, round-key index, 0..10.
- `rd_key`, output, 128, registered round key for `rd_addr`.
- `busy`, output, 1, high while expansion is in progress.
- `key_ready`, output, 1, high when all 11 round keys are valid; level signal.
- `done`, output, 1, one-cycle pulse when expansion completes.

## Operation
State machine states: IDLE, EXPAND, DONE.

- **IDLE or DONE, `start` high:**
  - Latch `key_in` into store[0] and into the working register `prev`.
  - Set `rnd` (4-bit) to 1, clear `key_ready`, go to EXPAND.
- **EXPAND, each cycle:**
  - Compute `t = word(prev[31:0], rnd)`.
  - Compute the new words: n0 = prev[127:96]^t, n1 = prev[95:64]^n0, n2 = prev[63:32]^n1, n3 = prev[31:0]^n2.
  - Write `{n0,n1,n2,n3}` to store[rnd] and to `prev`, then increment `rnd`.
  - The Rcon lookup inside `word` is 1-based: rnd=1 gives 01000000, rnd=10 gives 36000000.
- **EXPAND, `rnd`==NR:** after that write, go to DONE, set `key_ready`, pulse `done`.
- **`start` during EXPAND:** ignored; the in-progress expansion is neither restarted nor corrupted.
- **`start` in DONE:** re-expansion. `key_ready` drops on the accepting edge; store entries are overwritten progressively.
- **Reads:**
  - `rd_key` <= store[`rd_addr`] every cycle, independent of state.
  - `rd_addr` > 10 returns all zeros.
  - Reading during EXPAND returns whatever the entry currently holds: new data if already written this pass, otherwise stale. Consumers qualify reads with `key_ready`.
- **Reset:**
  - State goes to IDLE, `rnd`=0, `prev`=0, all store entries 0, `rd_key`=0.
  - `busy`=0, `key_ready`=0, `done`=0.
  - Reset mid-EXPAND abandons the expansion; nothing is retained.

## Timing
- Edge E0: `start` sampled high in IDLE/DONE; store[0] written; `busy`=1 from E0.
- Edges E1..E10: store[1]..store[10] written, one per edge.
- At E10: `busy`=0, `key_ready`=1, `done`=1 for exactly the cycle following E10.
- Start-to-ready latency: 10 clocks after the accepting edge (11 edges inclusive).
- Read latency: 1 clock from `rd_addr` to `rd_key`.
- A write to store[k] and a read of store[k] on the same edge returns the old value.
- One `word` instance is used. Its path (S-box plus four XOR levels) is the critical path; no pipelining inside EXPAND.
- `start` held high for several cycles: accepted once on entry. If still high in DONE it starts a new expansion, so the sender keeps it to a one-cycle pulse.

## Test plan
- **FIPS-197 key:** start with key 2b7e151628aed2a6abf7158809cf4f3c -> after `done`, rd_addr=0 gives 2b7e151628aed2a6abf7158809cf4f3c, rd_addr=1 gives a0fafe1788542cb123a339392a6c7605, rd_addr=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- **Cycle check:** `start` at edge E0 -> `busy` high E0..E10; `key_ready` and one-cycle `done` exactly at E10; no `done` at any other edge.
- **Start during EXPAND:** `start` pulsed during EXPAND at rnd=5 with key 000...0 -> ignored; final round 10 still d014f9a8c9ee2589e13f0cc8b6630ca6.
- **Re-expansion from DONE:** key 000102030405060708090a0b0c0d0e0f -> `key_ready` drops at the accepting edge; after `done`, rd_addr=10 gives 13111d7fe3944a17f307a78b4d2b30c5.
- **Reset mid-expansion:** `rst_n` low at rnd=4 -> all outputs 0 immediately (asynchronous); every rd_addr reads 0; a subsequent start expands correctly.
- **Out-of-range read:** rd_addr=11 and rd_addr=15 -> `rd_key` = 0 one cycle later.
